// File: rtl/ieee488_pkg.sv
// rtl/ieee488_pkg.sv - IEEE-488 device command constants, handshake state encodings, rx entry type
// Ports: none (package).
package ieee488_pkg;

   // Primary/secondary command groups (byte with bit 7 masked)
   localparam logic [7:0] LAG_BASE = 8'h20;
   localparam logic [7:0] UNL      = 8'h3F;
   localparam logic [7:0] TAG_BASE = 8'h40;
   localparam logic [7:0] UNT      = 8'h5F;
   localparam logic [7:0] SCG_BASE = 8'h60;

   // Acceptor handshake states
   localparam logic [1:0] AH_IDLE  = 2'd0;
   localparam logic [1:0] AH_READY = 2'd1;
   localparam logic [1:0] AH_ACPT  = 2'd2;

   // Source handshake states
   localparam logic [1:0] SH_IDLE    = 2'd0;
   localparam logic [1:0] SH_SETTLE  = 2'd1;
   localparam logic [1:0] SH_WAITRFD = 2'd2;
   localparam logic [1:0] SH_DAV     = 2'd3;

   typedef struct packed {
      logic [7:0] data;
      logic       atn;
      logic       eoi;
   } rx_entry_t;

endpackage

// File: rtl/ieee488_if.sv
// rtl/ieee488_if.sv - IEEE-488 bus lines seen by one device (all active-low)
// Ports: *_i = sampled wired-AND bus level, *_o = this device's drive (1/FF = released).
//        slave modport = device side, master modport = bus/controller side.
interface ieee488_if;
   logic [7:0] data_i;
   logic       atn_i;
   logic       ifc_i;
   logic       dav_i;
   logic       eoi_i;
   logic       nrfd_i;
   logic       ndac_i;
   logic [7:0] data_o;
   logic       dav_o;
   logic       eoi_o;
   logic       nrfd_o;
   logic       ndac_o;

   modport slave (
      input  data_i, atn_i, ifc_i, dav_i, eoi_i, nrfd_i, ndac_i,
      output data_o, dav_o, eoi_o, nrfd_o, ndac_o
   );

   modport master (
      output data_i, atn_i, ifc_i, dav_i, eoi_i, nrfd_i, ndac_i,
      input  data_o, dav_o, eoi_o, nrfd_o, ndac_o
   );
endinterface

// File: rtl/ieee488_sh.sv
// rtl/ieee488_sh.sv - IEEE-488 source handshake FSM with data settle counter
// Ports: clk/reset/ce; run = talking with ATN and IFC high; tx_* = host byte stream;
//        nrfd_i/ndac_i = bus levels; data_o/eoi_o/dav_o = active-low drives; tx_ready = accept pulse.
module ieee488_sh
   import ieee488_pkg::*;
#(
   parameter int unsigned SETTLE_CYC = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ce,
   input  logic       run,
   input  logic [7:0] tx_data,
   input  logic       tx_eoi,
   input  logic       tx_valid,
   input  logic       nrfd_i,
   input  logic       ndac_i,
   output logic [7:0] data_o,
   output logic       eoi_o,
   output logic       dav_o,
   output logic       tx_ready
);

   logic [1:0] state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] data_q, data_d;
   logic       eoi_q, eoi_d;
   logic       dav_q, dav_d;
   logic       ready_q, ready_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      eoi_d   = eoi_q;
      dav_d   = dav_q;
      ready_d = ready_q;
      if (ce) begin
         ready_d = 1'b0;
         if (!run) begin
            // Abort: release everything, no ready pulse so the host keeps the byte
            state_d = SH_IDLE;
            data_d  = 8'hFF;
            eoi_d   = 1'b1;
            dav_d   = 1'b1;
         end else begin
            case (state_q)
               SH_IDLE: begin
                  // The byte just acknowledged is still offered during the ready pulse
                  if (tx_valid && !ready_q) begin
                     data_d  = ~tx_data;
                     eoi_d   = ~tx_eoi;
                     cnt_d   = 8'(SETTLE_CYC);
                     state_d = SH_SETTLE;
                  end
               end
               SH_SETTLE: begin
                  if (cnt_q <= 8'd1) begin
                     cnt_d   = 8'd0;
                     state_d = SH_WAITRFD;
                  end else begin
                     cnt_d = cnt_q - 8'd1;
                  end
               end
               SH_WAITRFD: begin
                  if (nrfd_i) begin
                     dav_d   = 1'b0;
                     state_d = SH_DAV;
                  end
               end
               default: begin
                  if (ndac_i) begin
                     dav_d   = 1'b1;
                     data_d  = 8'hFF;
                     eoi_d   = 1'b1;
                     ready_d = 1'b1;
                     state_d = SH_IDLE;
                  end
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= SH_IDLE;
         cnt_q   <= 8'd0;
         data_q  <= 8'hFF;
         eoi_q   <= 1'b1;
         dav_q   <= 1'b1;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         eoi_q   <= eoi_d;
         dav_q   <= dav_d;
         ready_q <= ready_d;
      end
   end

   assign data_o   = data_q;
   assign eoi_o    = eoi_q;
   assign dav_o    = dav_q;
   assign tx_ready = ready_q;

endmodule

// File: rtl/ieee488_device.sv
// rtl/ieee488_device.sv - IEEE-488 device end: acceptor handshake, address decode, source handshake
// Ports: clk/reset(sync, active-high)/ce; bus = IEEE-488 lines (slave modport);
//        rx_* = received byte stream to host; tx_* = byte stream to talk; listening/talking = address state.
module ieee488_device
   import ieee488_pkg::*;
#(
   parameter int unsigned DEV_ADDR   = 8,
   parameter int unsigned SETTLE_CYC = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ce,
   ieee488_if.slave    bus,
   output logic [7:0]  rx_data,
   output logic        rx_atn,
   output logic        rx_eoi,
   output logic        rx_valid,
   input  logic        rx_ready,
   input  logic [7:0]  tx_data,
   input  logic        tx_eoi,
   input  logic        tx_valid,
   output logic        tx_ready,
   output logic        listening,
   output logic        talking
);

   localparam logic [7:0] MY_LAG = LAG_BASE | 8'(DEV_ADDR & 31);
   localparam logic [7:0] MY_TAG = TAG_BASE | 8'(DEV_ADDR & 31);

   logic [1:0] ah_state_q, ah_state_d;
   rx_entry_t  rx_q, rx_d;
   logic       rx_valid_q, rx_valid_d;
   logic       listening_q, listening_d;
   logic       talking_q, talking_d;
   logic       addressed_q, addressed_d;
   logic       participate;
   logic       latch;
   logic [7:0] byte_in;
   logic [7:0] cmd;
   logic       sh_run;

   always_comb begin
      participate = !bus.atn_i || listening_q;
      byte_in     = ~bus.data_i;
      cmd         = byte_in & 8'h7F;
      latch       = 1'b0;
      ah_state_d  = ah_state_q;
      rx_d        = rx_q;
      rx_valid_d  = rx_valid_q;
      listening_d = listening_q;
      talking_d   = talking_q;
      addressed_d = addressed_q;
      if (ce) begin
         if (!bus.ifc_i) begin
            ah_state_d  = AH_IDLE;
            rx_valid_d  = 1'b0;
            listening_d = 1'b0;
            talking_d   = 1'b0;
            addressed_d = 1'b0;
         end else begin
            if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
            if (!participate) begin
               ah_state_d = AH_IDLE;
            end else begin
               case (ah_state_q)
                  // Entering READY on the first ATN-low edge pulls NDAC before DAV is looked at
                  AH_IDLE:  ah_state_d = AH_READY;
                  AH_READY: begin
                     if (!bus.dav_i && !rx_valid_q) begin
                        ah_state_d = AH_ACPT;
                        latch      = 1'b1;
                     end
                  end
                  AH_ACPT:  if (bus.dav_i) ah_state_d = AH_READY;
                  default:  ah_state_d = AH_IDLE;
               endcase
            end
            if (latch) begin
               if (!bus.atn_i) begin
                  if (cmd == MY_LAG) begin
                     listening_d = 1'b1;
                     talking_d   = 1'b0;
                     addressed_d = 1'b1;
                  end else if (cmd == UNL) begin
                     listening_d = 1'b0;
                     addressed_d = 1'b0;
                  end else if (cmd == MY_TAG) begin
                     talking_d   = 1'b1;
                     listening_d = 1'b0;
                     addressed_d = 1'b1;
                  end else if (cmd >= TAG_BASE && cmd <= UNT) begin
                     // Another talker address implicitly untalks us
                     talking_d   = 1'b0;
                     addressed_d = 1'b0;
                  end else if (cmd >= LAG_BASE && cmd < UNL) begin
                     addressed_d = 1'b0;
                  end else if (cmd >= SCG_BASE) begin
                     // Secondary goes to the host only right after our own primary
                     if (addressed_q) begin
                        rx_d       = '{data: byte_in, atn: 1'b1, eoi: !bus.eoi_i};
                        rx_valid_d = 1'b1;
                     end
                     addressed_d = 1'b0;
                  end
               end else begin
                  rx_d       = '{data: byte_in, atn: 1'b0, eoi: !bus.eoi_i};
                  rx_valid_d = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ah_state_q  <= AH_IDLE;
         rx_q        <= '{data: 8'h00, atn: 1'b0, eoi: 1'b0};
         rx_valid_q  <= 1'b0;
         listening_q <= 1'b0;
         talking_q   <= 1'b0;
         addressed_q <= 1'b0;
      end else begin
         ah_state_q  <= ah_state_d;
         rx_q        <= rx_d;
         rx_valid_q  <= rx_valid_d;
         listening_q <= listening_d;
         talking_q   <= talking_d;
         addressed_q <= addressed_d;
      end
   end

   // NRFD is only released in READY with room in the rx buffer
   assign bus.nrfd_o = (ah_state_q == AH_IDLE) || (ah_state_q == AH_READY && !rx_valid_q);
   assign bus.ndac_o = (ah_state_q != AH_READY);

   assign sh_run = talking_q && bus.atn_i && bus.ifc_i;

   ieee488_sh #(.SETTLE_CYC(SETTLE_CYC)) u_sh (
      .clk      (clk),
      .reset    (reset),
      .ce       (ce),
      .run      (sh_run),
      .tx_data  (tx_data),
      .tx_eoi   (tx_eoi),
      .tx_valid (tx_valid),
      .nrfd_i   (bus.nrfd_i),
      .ndac_i   (bus.ndac_i),
      .data_o   (bus.data_o),
      .eoi_o    (bus.eoi_o),
      .dav_o    (bus.dav_o),
      .tx_ready (tx_ready)
   );

   assign rx_data   = rx_q.data;
   assign rx_atn    = rx_q.atn;
   assign rx_eoi    = rx_q.eoi;
   assign rx_valid  = rx_valid_q;
   assign listening = listening_q;
   assign talking   = talking_q;

endmodule

// File: doc/ieee488_device.md
Name: ieee488_device

Overview:
- Device-side IEEE-488 interface: the peripheral (disk/printer) end of the bus whose controller end is the PET PIA/VIA port.
- Implements the acceptor handshake (AH), the source handshake (SH) and listen/talk address decode for one primary address.
- Bus side connects to the shared wired-AND IEEE-488 bus module. Host side is two byte streams with valid/ready handshakes, toward the drive controller logic.

Parameters:
DEV_ADDR, 8, primary address 0..30 (5 bits)
SETTLE_CYC, 2, ce cycles between data/EOI driven and DAV asserted (T1 settle)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ce  in  1  clock enable; all state advances only on clk edges with ce=1
ieee488_data_i  in  8  bus data, active-low (byte = ~data_i)
ieee488_atn_i  in  1  ATN, active-low
ieee488_ifc_i  in  1  IFC, active-low
ieee488_dav_i  in  1  DAV, active-low
ieee488_eoi_i  in  1  EOI, active-low
ieee488_nrfd_i  in  1  NRFD, active-low
ieee488_ndac_i  in  1  NDAC, active-low
ieee488_data_o  out  8  data drive, active-low; 8'hFF = released
ieee488_dav_o  out  1  DAV drive; 1 = released
ieee488_eoi_o  out  1  EOI drive; 1 = released
ieee488_nrfd_o  out  1  NRFD drive; 1 = released
ieee488_ndac_o  out  1  NDAC drive; 1 = released
rx_data  out  8  received byte
rx_atn  out  1  1 = secondary command byte, 0 = data byte
rx_eoi  out  1  EOI was asserted with the byte
rx_valid  out  1  rx byte available
rx_ready  in  1  host consumes rx byte
tx_data  in  8  byte to talk
tx_eoi  in  1  assert EOI with this byte
tx_valid  in  1  tx byte offered
tx_ready  out  1  one-cycle pulse: tx byte accepted by listener(s)
listening  out  1  addressed as listener
talking  out  1  addressed as talker

Behaviour:
- Reset or IFC low (sampled on a ce cycle):
  - all bus outputs released (1 / 8'hFF);
  - listening = talking = rx_valid = tx_ready = 0;
  - AH = IDLE, SH = IDLE, addressed flag cleared.
  - A reset asserted mid-handshake takes effect on the next edge.
- Bus inputs are synchronous to clk; no synchronizers.
- rx buffer: one entry. rx_valid is cleared on a ce edge where rx_valid & rx_ready.
- AH participates when atn_i=0, or when (listening & atn_i=1).
- AH states:
  - IDLE: ndac_o=1, nrfd_o=1.
  - READY: ndac_o=0; nrfd_o=1 only if rx buffer empty, else 0. On dav_i=0 with buffer empty → ACPT; latch ~data_i, ~eoi_i, ~atn_i.
  - ACPT: nrfd_o=0, ndac_o=1. On dav_i=1 → READY (ndac_o=0 again).
  - Participation lost from any state → IDLE on the same ce edge.
  - ATN falling: ndac_o low on the first ce edge at which atn_i=0 is sampled. This is 1 ce cycle latency, so all devices hold NDAC.
- Byte handling when latched under ATN (cmd=byte&8'h7F):
  - 0x20|DEV_ADDR (LAG own): listening=1, talking=0, addressed=1.
  - 0x3F (UNL): listening=0, addressed=0.
  - 0x40|DEV_ADDR (TAG own): talking=1, listening=0, addressed=1.
  - 0x40..0x5E other address, or 0x5F (UNT): talking=0, addressed=0.
  - Other 0x20..0x3E: addressed=0.
  - 0x60..0x7F (secondary, full byte including 0xE0/0xF0 forms): if addressed, place byte in rx buffer with rx_atn=1. addressed is then cleared.
  - Primary commands never occupy the rx buffer.
- Byte latched with ATN high (listening): place in rx buffer with rx_atn=0 and rx_eoi.
- SH runs only while talking & atn_i=1.
- SH states:
  - IDLE: on tx_valid, drive data_o=~tx_data and eoi_o=~tx_eoi; load settle counter = SETTLE_CYC → SETTLE.
  - SETTLE: decrement counter; at 0 → WAITRFD.
  - WAITRFD: on nrfd_i=1 → DAV with dav_o=0.
  - DAV: on ndac_i=1, release dav_o, data_o and eoi_o; pulse tx_ready for one ce cycle → IDLE.
- ATN low, IFC low or talking=0 in any SH state: SH → IDLE on the same edge and all SH lines are released. No tx_ready is pulsed, so the host retains the byte.
- ATN low and dav_i low sampled on the same edge: AH takes ATN and enters READY. DAV is serviced the next cycle.

Decomposition:
- Package ieee488_pkg holds:
  - command constants: LAG_BASE 0x20, UNL 0x3F, TAG_BASE 0x40, UNT 0x5F, SCG_BASE 0x60;
  - AH/SH state encodings.
- One sub-module: ieee488_sh (source handshake FSM plus settle counter).
- AH and address decode stay in the top.

Test Plan:
- DEV_ADDR=8. Controller sends 0x28 under ATN, then 0x6F. → listening=1; rx_data=0x6F, rx_atn=1; ndac_o low within 1 ce after ATN falls.
- ATN released, controller sends 0x41 then 0x42 with EOI. → rx bytes 0x41 (rx_eoi=0) and 0x42 (rx_eoi=1). nrfd_o held 0 while rx_valid=1 and rx_ready=0.
- Send 0x48 under ATN, release ATN. Host offers 0x55 with tx_eoi=1; listener model toggles NRFD/NDAC. → data_o=0xAA and eoi_o=0 before dav_o falls, after ≥SETTLE_CYC ce cycles; single tx_ready pulse.
- While talking with SH in DAV, pull ATN low. → dav_o, data_o, eoi_o released the same edge; no tx_ready; ndac_o=0 next ce.
- Send 0x29 (other listener), then 0x5F, then 0x3F. → listening/talking unchanged by 0x29; both 0 after UNT and UNL; following 0x60 not forwarded.
- IFC low mid-ACPT. → all outputs released; listening=talking=0; AH IDLE.
